image_size_down_x2: RTL and testbench
=====================================

# image_size_down_x2

Streaming 2:1 image downscaler in both dimensions for RGB565 video. It accepts a raster-ordered pixel stream qualified by `tvalid_i` and emits one output pixel per 2×2 input block, computed as the truncated per-channel box average. It sits in the video pipeline between the capture/ISP stage and the frame-buffer writer, and halves the bandwidth of the stored image.

## Interface
Parameters:
- `MAX_WIDTH`, 1920: largest supported `width_i`; sets line-buffer depth to `MAX_WIDTH/2`.
- `AW`, 10: line-buffer address width; must satisfy `2^AW ≥ MAX_WIDTH/2`.

Ports:
- `clk`  in  1: clock.
- `rstn`  in  1: reset; asynchronous, active-low.
- `width_i`  in  16: input frame width in pixels; must be even and ≤ `MAX_WIDTH`.
- `height_i`  in  16: input frame height in lines; must be even.
- `tdata_i`  in  16: input pixel, RGB565 (R `[15:11]`, G `[10:5]`, B `[4:0]`).
- `tvalid_i`  in  1: input pixel valid. There is no ready signal; every valid cycle is consumed.
- `tdata_o`  out  16: output pixel, RGB565.
- `tvalid_o`  out  1: output valid; high for exactly one cycle per output pixel.

## Operation
- Position counters `x` (0..W-1) and `y` (0..H-1) advance only on `tvalid_i`. Gaps of any length between valid pixels, including blanking, are ignored.
- `x` wraps at W-1 and `y` increments. `y` wraps at H-1 and the next frame begins.
- W and H are latched from `width_i`/`height_i` on the first valid pixel of each frame (x=0, y=0) and held for that frame.
- Even `x`: register the pixel's channels as the pending horizontal half.
- Odd `x`, even `y`:
  - Form the pair sum per channel: R 6b, G 7b, B 6b, concatenated as 19b.
  - Write the sum to the line buffer at address `x>>1`.
- Odd `x`, odd `y`:
  - Add the current pair sum to the line-buffer entry at `x>>1`, giving R 7b, G 8b, B 7b.
  - Output each channel `>>2`, truncated.
- Output count per frame is (W/2)·(H/2). Outputs appear only during odd input lines.
- Odd W or H, although disallowed, must not hang the block: the trailing column or row is dropped.
- There is no start-of-frame input. Frame alignment relies on reset and on correct W/H.

## Timing
- Reset values: `tdata_o`=0, `tvalid_o`=0, x=0, y=0, pending half=0.
- The line buffer has a registered read. The read address `x>>1` is issued on the even-x pixel of an odd line, so the data is available at the following odd-x pixel. Valid gaps do not disturb this because the read data is held.
- Latency: `tvalid_o`/`tdata_o` are registered one `clk` after the odd-x/odd-y input pixel is accepted.
- `tdata_o` holds its last value while `tvalid_o`=0.
- Asserting `rstn` low mid-frame aborts immediately. The line-buffer contents are not cleared, but they are overwritten before use.

## Structure
- Shared package:
  - RGB565 field positions.
  - Pair-sum widths (6/7/6 bits).
  - `MAX_WIDTH` default.
- One sub-module `linebuf_sdp`: simple dual-port RAM, 19b × `2^AW`, one write port and one registered read port, inferred as block RAM.
- Top level contains:
  - the x/y counters;
  - the W/H latch;
  - the pending-half register;
  - the adders and output register.

## Test plan
- Constant pixel 16'hFFFF, W=4, H=2, continuous valid -> 2 outputs, both 16'hFFFF, each 1 cycle after input x=1 and x=3 of line 1.
- W=2, H=2 with pixels 16'h2102, 0, 0, 0 -> single output 16'h0840 (R=1, G=2, B=0).
- Truncation: W=2, H=2 with pixels 16'h0821, 0, 0, 0 -> output 16'h0000.
- W=1280, H=720, 1280-pixel valid burst per 2201-cycle line, data = running counter -> 640 outputs on every odd line, none on even lines, 230400 per frame; the first output of frame 2 appears after line 1 of frame 2.
- Valid deasserted every other cycle, W=4, H=2 -> same output values as continuous valid, each 1 cycle after its odd-x/odd-y input.
- `rstn` pulsed low at line 1, x=2 of a W=4 frame -> `tvalid_o`=0 asynchronously; the next valid pixel is treated as x=0, y=0.

Source files
------------

// File: rtl/image_size_down_x2_pkg.sv
// Shared definitions for the 2:1 RGB565 box-average downscaler.
package image_size_down_x2_pkg;
  localparam int MAX_WIDTH_DEF = 1920;

  localparam int R_MSB = 15, R_LSB = 11;
  localparam int G_MSB = 10, G_LSB = 5;
  localparam int B_MSB = 4,  B_LSB = 0;

  localparam int RS_W  = 6;
  localparam int GS_W  = 7;
  localparam int BS_W  = 6;
  localparam int SUM_W = RS_W + GS_W + BS_W;

  typedef struct packed {
    logic [R_MSB-R_LSB:0] r;
    logic [G_MSB-G_LSB:0] g;
    logic [B_MSB-B_LSB:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [RS_W-1:0] r;
    logic [GS_W-1:0] g;
    logic [BS_W-1:0] b;
  } pair_sum_t;
endpackage

// File: rtl/image_size_down_x2_linebuf_sdp.sv
// Simple dual-port line buffer: one write port, one registered read port that holds its data.
module linebuf_sdp #(
  parameter int DW    = 19,
  parameter int AW    = 10,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= r_mem[rd_addr];
  end
endmodule

// File: rtl/image_size_down_x2.sv
// Streaming 2x2 box-average downscaler for raster RGB565; one output per 2x2 block.
module image_size_down_x2
  import image_size_down_x2_pkg::*;
#(
  parameter int MAX_WIDTH = MAX_WIDTH_DEF,
  parameter int AW        = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] width_i,
  input  logic [15:0] height_i,
  input  logic [15:0] tdata_i,
  input  logic        tvalid_i,
  output logic [15:0] tdata_o,
  output logic        tvalid_o
);
  logic [15:0] r_x, r_y, r_w, r_h;
  rgb565_t     r_pend;
  rgb565_t     w_pix, w_out;
  pair_sum_t   w_pair, w_rd;
  logic        w_sof, w_x_last, w_y_last;
  logic [15:0] w_w, w_h;
  logic        w_wr, w_rd_en, w_emit;
  logic [AW-1:0] w_addr;

  // Frame dimensions come straight from the inputs on the first pixel of a frame.
  assign w_sof    = (r_x == '0) && (r_y == '0);
  assign w_w      = w_sof ? width_i  : r_w;
  assign w_h      = w_sof ? height_i : r_h;
  assign w_x_last = ({1'b0, r_x} + 17'd1) >= {1'b0, w_w};
  assign w_y_last = ({1'b0, r_y} + 17'd1) >= {1'b0, w_h};

  assign w_pix    = rgb565_t'(tdata_i);
  assign w_pair.r = {1'b0, r_pend.r} + {1'b0, w_pix.r};
  assign w_pair.g = {1'b0, r_pend.g} + {1'b0, w_pix.g};
  assign w_pair.b = {1'b0, r_pend.b} + {1'b0, w_pix.b};

  // Even lines store pair sums; odd lines prefetch on even x and combine on odd x.
  assign w_addr  = r_x[AW:1];
  assign w_wr    = tvalid_i &  r_x[0] & ~r_y[0];
  assign w_rd_en = tvalid_i & ~r_x[0] &  r_y[0];
  assign w_emit  = tvalid_i &  r_x[0] &  r_y[0];

  assign w_out.r = 5'(({1'b0, w_pair.r} + {1'b0, w_rd.r}) >> 2);
  assign w_out.g = 6'(({1'b0, w_pair.g} + {1'b0, w_rd.g}) >> 2);
  assign w_out.b = 5'(({1'b0, w_pair.b} + {1'b0, w_rd.b}) >> 2);

  linebuf_sdp #(
    .DW(SUM_W), .AW(AW), .DEPTH(MAX_WIDTH / 2)
  ) u_linebuf (
    .clk    (clk),
    .wr_en  (w_wr),
    .wr_addr(w_addr),
    .wr_data(w_pair),
    .rd_en  (w_rd_en),
    .rd_addr(w_addr),
    .rd_data(w_rd)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x      <= '0;
      r_y      <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_pend   <= '0;
      tdata_o  <= '0;
      tvalid_o <= 1'b0;
    end else begin
      tvalid_o <= w_emit;
      if (w_emit) tdata_o <= w_out;
      if (tvalid_i) begin
        if (w_sof) begin
          r_w <= width_i;
          r_h <= height_i;
        end
        if (!r_x[0]) r_pend <= w_pix;
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? '0 : r_y + 16'd1;
        end else begin
          r_x <= r_x + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_image_size_down_x2.sv
// Self-checking bench: table vectors, reset corner case, randomized frames vs. a frame-array model.
module tb_image_size_down_x2;
  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] width_i, height_i, tdata_i, tdata_o;
  logic        tvalid_i, tvalid_o;

  image_size_down_x2 dut (
    .clk(clk), .rstn(rstn), .width_i(width_i), .height_i(height_i),
    .tdata_i(tdata_i), .tvalid_i(tvalid_i), .tdata_o(tdata_o), .tvalid_o(tvalid_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] d; int t; } obs_t;
  obs_t        got[$];
  logic [15:0] exp_d[$];
  int          exp_t[$];

  always @(negedge clk) if (tvalid_o) got.push_back('{tdata_o, cyc});

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Reference model: full frame stored as a 2D array, each 2x2 block averaged when complete.
  logic [15:0] fr [0:15][0:63];
  int bx = 0, by = 0, bw = 0, bh = 0;

  function automatic logic [15:0] avg4(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] e);
    int r, g, bl;
    r  = int'(a[15:11]) + int'(b[15:11]) + int'(c[15:11]) + int'(e[15:11]);
    g  = int'(a[10:5])  + int'(b[10:5])  + int'(c[10:5])  + int'(e[10:5]);
    bl = int'(a[4:0])   + int'(b[4:0])   + int'(c[4:0])   + int'(e[4:0]);
    return {5'(r / 4), 6'(g / 4), 5'(bl / 4)};
  endfunction

  task automatic send_px(input logic [15:0] d, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    if (bx == 0 && by == 0) begin bw = int'(width_i); bh = int'(height_i); end
    tdata_i  = d;
    tvalid_i = 1'b1;
    fr[by][bx] = d;
    if ((bx % 2 == 1) && (by % 2 == 1)) begin
      exp_d.push_back(avg4(fr[by-1][bx-1], fr[by-1][bx], fr[by][bx-1], d));
      exp_t.push_back(cyc + 1);
    end
    bx++;
    if (bx >= bw) begin
      bx = 0; by++;
      if (by >= bh) by = 0;
    end
    @(posedge clk); #1;
    tvalid_i = 1'b0;
  endtask

  task automatic drain(input string name, input bit use_tbl, input int nexp,
                       input logic [15:0] te0, input logic [15:0] te1);
    obs_t o;
    logic [15:0] ed;
    int et, k;
    repeat (4) @(posedge clk);
    #1;
    chk({name, " count"}, got.size(), use_tbl ? nexp : exp_d.size());
    k = 0;
    while (got.size() > 0 && exp_d.size() > 0) begin
      o  = got.pop_front();
      ed = exp_d.pop_front();
      et = exp_t.pop_front();
      chk($sformatf("%s data%0d", name, k), o.d, use_tbl ? ((k == 0) ? te0 : te1) : ed);
      chk($sformatf("%s cycle%0d", name, k), o.t, et);
      k++;
    end
    got.delete(); exp_d.delete(); exp_t.delete();
  endtask

  task automatic send_frame(input int w, input int h);
    width_i = 16'(w); height_i = 16'(h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        send_px(16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        if (x == 0 && y == 0) begin width_i = 16'($urandom); height_i = 16'($urandom); end
      end
  endtask

  typedef struct {
    int w, h, gap, nexp;
    logic [15:0] px [8];
    logic [15:0] e0, e1;
  } vec_t;
  vec_t tbl [6];

  initial begin
    tbl[0].w = 4; tbl[0].h = 2; tbl[0].gap = 0; tbl[0].nexp = 2;
    tbl[0].px = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[0].e0 = 16'hFFFF; tbl[0].e1 = 16'hFFFF;
    tbl[1].w = 2; tbl[1].h = 2; tbl[1].gap = 0; tbl[1].nexp = 1;
    tbl[1].px = '{16'h2102, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    tbl[1].e0 = 16'h0840; tbl[1].e1 = 16'h0;
    tbl[2].w = 2; tbl[2].h = 2; tbl[2].gap = 0; tbl[2].nexp = 1;
    tbl[2].px = '{16'h0821, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    tbl[2].e0 = 16'h0000; tbl[2].e1 = 16'h0;
    tbl[3].w = 4; tbl[3].h = 2; tbl[3].gap = 0; tbl[3].nexp = 2;
    tbl[3].px = '{16'hF800, 16'h07E0, 16'h001F, 16'h0000, 16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
    tbl[3].e0 = 16'h7BE0; tbl[3].e1 = 16'h39F7;
    tbl[4] = tbl[0]; tbl[4].gap = 1;
    tbl[5] = tbl[3]; tbl[5].gap = 1;

    rstn = 1'b0; tvalid_i = 1'b0; tdata_i = '0; width_i = 16'd4; height_i = 16'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("reset tvalid_o", tvalid_o, 1'b0);
    chk("reset tdata_o", tdata_o, 16'h0);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      width_i = 16'(tbl[i].w); height_i = 16'(tbl[i].h);
      for (int p = 0; p < tbl[i].w * tbl[i].h; p++)
        send_px(tbl[i].px[p], (p == 0) ? 0 : tbl[i].gap);
      drain($sformatf("tbl%0d", i), 1'b1, tbl[i].nexp, tbl[i].e0, tbl[i].e1);
    end

    // Reset mid-frame while an output is being presented, then restart at x=0,y=0.
    width_i = 16'd4; height_i = 16'd2;
    for (int p = 0; p < 6; p++) send_px(16'hFFFF, 0);
    chk("pre-reset tvalid_o", tvalid_o, 1'b1);
    rstn = 1'b0;
    #1;
    chk("async reset tvalid_o", tvalid_o, 1'b0);
    chk("async reset tdata_o", tdata_o, 16'h0);
    void'(exp_d.pop_back()); void'(exp_t.pop_back());
    bx = 0; by = 0;
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    got.delete();
    width_i = 16'd2; height_i = 16'd2;
    send_px(16'h2102, 0); send_px(16'h0, 0); send_px(16'h0, 0); send_px(16'h0, 0);
    drain("post-reset", 1'b1, 1, 16'h0840, 16'h0);

    send_frame(8, 4);  drain("rand 8x4", 1'b0, 0, 16'h0, 16'h0);
    send_frame(64, 8); drain("rand 64x8 a", 1'b0, 0, 16'h0, 16'h0);
    send_frame(64, 8); drain("rand 64x8 b", 1'b0, 0, 16'h0, 16'h0);
    send_frame(5, 3);  drain("rand odd 5x3", 1'b0, 0, 16'h0, 16'h0);
    send_frame(6, 4);  drain("rand 6x4", 1'b0, 0, 16'h0, 16'h0);
    send_frame(2, 2);  drain("rand 2x2", 1'b0, 0, 16'h0, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
